// File: rtl/key_schedule_ctrl_pkg.sv
// Shared definitions for the AES-128 round key generator: FSM states,
// key/round constants and the round constant (Rcon) table.
package key_schedule_ctrl_pkg;

   localparam int AES_KEY_BITS  = 128;
   localparam int AES128_ROUNDS = 10;

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      SUB,
      MIX,
      DONE
   } ks_state_t;

   // Rcon bytes for produced rounds 1..10, stored from round 1 upward
   localparam logic [7:0] RCON_TABLE [AES128_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round constant for the round being produced; rounds outside 1..10 yield zero
   function automatic logic [7:0] rcon_for(input logic [3:0] round);
      logic [7:0] value;
      value = 8'h00;
      if ((round >= 4'd1) && (round <= 4'(AES128_ROUNDS))) begin
         value = RCON_TABLE[round - 4'd1];
      end
      return value;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_sbox.sv
// Combinational AES forward S-box lookup. A single instance is time-shared
// by the key schedule controller, one byte per cycle.
module sbox_LUT (
   input  logic [7:0] addr,
   output logic [7:0] data
);

   // Element 0 sits in the leftmost position, so SBOX[addr] reads entry addr
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign data = SBOX[addr];

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion controller. Produces round keys 0..NUM_ROUNDS one at
// a time over a valid/ready handshake, using one shared S-box for the four
// SubWord bytes of every round.
import key_schedule_ctrl_pkg::*;

module key_schedule_ctrl #(
   parameter int NUM_ROUNDS = AES128_ROUNDS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [AES_KEY_BITS-1:0] key_in,
   input  logic                    start,
   output logic                    busy,
   output logic [AES_KEY_BITS-1:0] rk_out,
   output logic [3:0]              rk_index,
   output logic                    rk_valid,
   input  logic                    rk_ready,
   output logic                    done
);

   localparam logic [3:0] LAST_INDEX = 4'(NUM_ROUNDS);

   ks_state_t               state;
   ks_state_t               state_next;
   logic [AES_KEY_BITS-1:0] round_key;
   logic [3:0]              round_index;
   logic [31:0]             temp;
   logic [1:0]              byte_cnt;
   logic [7:0]              sbox_in;
   logic [7:0]              sbox_out;
   logic [31:0]             t_word;
   logic [31:0]             w0_next;
   logic [31:0]             w1_next;
   logic [31:0]             w2_next;
   logic [31:0]             w3_next;

   sbox_LUT u_sbox (
      .addr (sbox_in),
      .data (sbox_out)
   );

   // Status outputs decode straight from the state register, so reset clears them at once
   assign busy     = (state != IDLE);
   assign rk_valid = (state == EMIT);
   assign done     = (state == DONE);
   assign rk_out   = round_key;
   assign rk_index = round_index;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: only EMIT waits on the consumer, SUB counts four bytes
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               state_next = (round_index == LAST_INDEX) ? DONE : SUB;
            end
         end
         SUB: begin
            if (byte_cnt == 2'd3) begin
               state_next = MIX;
            end
         end
         MIX:     state_next = EMIT;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Feed byte n of RotWord(w3), i.e. w3 byte n+1 wrapping to byte 0, into the S-box
   always_comb begin
      sbox_in = 8'h00;
      case (byte_cnt)
         2'd0: sbox_in = round_key[23:16];
         2'd1: sbox_in = round_key[15:8];
         2'd2: sbox_in = round_key[7:0];
         2'd3: sbox_in = round_key[31:24];
         default: sbox_in = 8'h00;
      endcase
   end

   // Word chain of one expansion round, using the substituted word gathered in temp
   always_comb begin
      t_word  = temp ^ {rcon_for(round_index + 4'd1), 24'h000000};
      w0_next = round_key[127:96] ^ t_word;
      w1_next = round_key[95:64]  ^ w0_next;
      w2_next = round_key[63:32]  ^ w1_next;
      w3_next = round_key[31:0]   ^ w2_next;
   end

   // Datapath registers: load key on start, gather S-box bytes in SUB, commit the new key in MIX
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_key   <= '0;
         round_index <= '0;
         temp        <= '0;
         byte_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  round_key   <= key_in;
                  round_index <= '0;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  byte_cnt <= '0;
               end
            end
            SUB: begin
               case (byte_cnt)
                  2'd0: temp[31:24] <= sbox_out;
                  2'd1: temp[23:16] <= sbox_out;
                  2'd2: temp[15:8]  <= sbox_out;
                  2'd3: temp[7:0]   <= sbox_out;
                  default: temp <= temp;
               endcase
               byte_cnt <= byte_cnt + 2'd1;
            end
            MIX: begin
               round_key   <= {w0_next, w1_next, w2_next, w3_next};
               round_index <= round_index + 4'd1;
            end
            default: begin
               round_key <= round_key;
            end
         endcase
      end
   end

endmodule
